// File: rtl/hazard_detection.sv
// Load-use and branch-operand hazard detection; stall outputs are combinational.
// Define HAZARD_STALL_COUNT_EN to compile in the saturating stall counter.
module hazard_detection #(
   parameter logic [5:0]  BRANCH_OPCODE = 6'b000011,
   parameter int unsigned COUNT_WIDTH   = 32
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   idExMemRead,
   input  logic                   idExRegWrite,
   input  logic                   exMemRegWrite,
   input  logic [4:0]             idExRt,
   input  logic [4:0]             idExRd,
   input  logic [4:0]             ifIdRs,
   input  logic [4:0]             ifIdRt,
   input  logic [4:0]             exMemRd,
   input  logic [5:0]             opCode,
   output logic                   pcWrite,
   output logic                   ifIdWrite,
   output logic                   bubbleInstruction,
   output logic [COUNT_WIDTH-1:0] stallCount
);

   logic matchIdExRt;
   logic matchIdExRd;
   logic matchExMemRd;
   logic isBranch;
   logic loadUseHazard;
   logic branchHazard;
   logic stall;

   // Register 0 is hardwired to zero, so it can never carry a dependency.
   assign matchIdExRt  = (idExRt  != 5'd0) && ((idExRt  == ifIdRs) || (idExRt  == ifIdRt));
   assign matchIdExRd  = (idExRd  != 5'd0) && ((idExRd  == ifIdRs) || (idExRd  == ifIdRt));
   assign matchExMemRd = (exMemRd != 5'd0) && ((exMemRd == ifIdRs) || (exMemRd == ifIdRt));

   assign isBranch      = (opCode == BRANCH_OPCODE);
   assign loadUseHazard = idExMemRead && matchIdExRt;
   assign branchHazard  = isBranch && ((idExRegWrite && matchIdExRd) ||
                                       (exMemRegWrite && matchExMemRd));

   assign stall = ~reset && (loadUseHazard || branchHazard);

   assign pcWrite           = ~stall;
   assign ifIdWrite         = ~stall;
   assign bubbleInstruction = stall;

`ifdef HAZARD_STALL_COUNT_EN
   logic [COUNT_WIDTH-1:0] countQ;

   // Saturate rather than wrap so a long run never reports a tiny count.
   always_ff @(posedge clk) begin
      if (reset) begin
         countQ <= '0;
      end else if (stall && (countQ != {COUNT_WIDTH{1'b1}})) begin
         countQ <= countQ + 1'b1;
      end
   end

   assign stallCount = countQ;
`else
   logic unusedClk;

   assign unusedClk  = clk;
   assign stallCount = '0;
`endif

endmodule

// File: tb/tb_hazard_detection.sv
// Bench for hazard_detection: vector table, scoreboard of expected stall outputs,
// and hand sequences for counter hold, reset-mid-stall and saturation.
module tb_hazard_detection;

   logic        clk;
   logic        reset;
   logic        idExMemRead;
   logic        idExRegWrite;
   logic        exMemRegWrite;
   logic [4:0]  idExRt;
   logic [4:0]  idExRd;
   logic [4:0]  ifIdRs;
   logic [4:0]  ifIdRt;
   logic [4:0]  exMemRd;
   logic [5:0]  opCode;
   logic        pcWrite;
   logic        ifIdWrite;
   logic        bubbleInstruction;
   logic [31:0] stallCount;
   logic        pcWrite2;
   logic        ifIdWrite2;
   logic        bubbleInstruction2;
   logic [1:0]  stallCount2;

   int testsRun;
   int testsFailed;

   logic [2:0]  exp_q[$];
   logic        curExpStall;
   logic [31:0] modelCount;
   logic [1:0]  modelCount2;

   typedef struct {
      logic       memRead;
      logic       exRegWrite;
      logic       memRegWrite;
      logic [4:0] exRt;
      logic [4:0] exRd;
      logic [4:0] rs;
      logic [4:0] rt;
      logic [4:0] memRd;
      logic [5:0] op;
      logic       expStall;
   } vec_t;

   vec_t vecs[12];

   hazard_detection dut (
      .clk(clk), .reset(reset),
      .idExMemRead(idExMemRead), .idExRegWrite(idExRegWrite), .exMemRegWrite(exMemRegWrite),
      .idExRt(idExRt), .idExRd(idExRd), .ifIdRs(ifIdRs), .ifIdRt(ifIdRt),
      .exMemRd(exMemRd), .opCode(opCode),
      .pcWrite(pcWrite), .ifIdWrite(ifIdWrite), .bubbleInstruction(bubbleInstruction),
      .stallCount(stallCount)
   );

   hazard_detection #(.COUNT_WIDTH(2)) dutNarrow (
      .clk(clk), .reset(reset),
      .idExMemRead(idExMemRead), .idExRegWrite(idExRegWrite), .exMemRegWrite(exMemRegWrite),
      .idExRt(idExRt), .idExRd(idExRd), .ifIdRs(ifIdRs), .ifIdRt(ifIdRt),
      .exMemRd(exMemRd), .opCode(opCode),
      .pcWrite(pcWrite2), .ifIdWrite(ifIdWrite2), .bubbleInstruction(bubbleInstruction2),
      .stallCount(stallCount2)
   );

   // clock / reference counter model
   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (reset) begin
         modelCount  <= '0;
         modelCount2 <= '0;
      end else if (curExpStall) begin
         if (modelCount != 32'hFFFF_FFFF) modelCount <= modelCount + 1;
         if (modelCount2 != 2'b11) modelCount2 <= modelCount2 + 1;
      end
   end

   // driver tasks
   task automatic driveInputs(input vec_t v);
      idExMemRead   = v.memRead;
      idExRegWrite  = v.exRegWrite;
      exMemRegWrite = v.memRegWrite;
      idExRt        = v.exRt;
      idExRd        = v.exRd;
      ifIdRs        = v.rs;
      ifIdRt        = v.rt;
      exMemRd       = v.memRd;
      opCode        = v.op;
   endtask

   task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
      testsRun++;
      if (act !== exp) begin
         testsFailed++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Drive one cycle of stimulus, queue the expectation, compare at the falling edge.
   task automatic applyCheck(input vec_t v, input logic rst, input string name);
      logic [2:0]  exp;
      logic [31:0] expCnt;
      logic [1:0]  expCnt2;
      @(posedge clk);
      #1;
      reset = rst;
      driveInputs(v);
      curExpStall = v.expStall;
      exp_q.push_back({~v.expStall, ~v.expStall, v.expStall});
      @(negedge clk);
      if (exp_q.size() == 0) begin
         testsRun++;
         testsFailed++;
         $display("FAIL %s: scoreboard empty", name);
      end else begin
         exp = exp_q.pop_front();
         checkVal({name, ".outs"}, {29'd0, pcWrite, ifIdWrite, bubbleInstruction}, {29'd0, exp});
         checkVal({name, ".outsNarrow"}, {29'd0, pcWrite2, ifIdWrite2, bubbleInstruction2}, {29'd0, exp});
      end
`ifdef HAZARD_STALL_COUNT_EN
      expCnt  = modelCount;
      expCnt2 = modelCount2;
`else
      expCnt  = '0;
      expCnt2 = '0;
`endif
      checkVal({name, ".count"}, stallCount, expCnt);
      checkVal({name, ".countNarrow"}, {30'd0, stallCount2}, {30'd0, expCnt2});
   endtask

   function automatic vec_t mk(input logic mr, input logic erw, input logic mrw,
                               input logic [4:0] ert, input logic [4:0] erd,
                               input logic [4:0] rs, input logic [4:0] rt,
                               input logic [4:0] mrd, input logic [5:0] op,
                               input logic es);
      vec_t v;
      v.memRead = mr; v.exRegWrite = erw; v.memRegWrite = mrw;
      v.exRt = ert; v.exRd = erd; v.rs = rs; v.rt = rt; v.memRd = mrd;
      v.op = op; v.expStall = es;
      return v;
   endfunction

   initial begin
      vec_t loadUse;
      vec_t both;
      vec_t idle;
      vec_t rv;
      logic [4:0] r;
      testsRun    = 0;
      testsFailed = 0;
      curExpStall = 1'b0;
      reset       = 1'b1;
      idle        = mk(0, 0, 0, 0, 0, 0, 0, 0, 6'd0, 0);
      driveInputs(idle);

      vecs[0]  = mk(0, 0, 0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0,     0);
      vecs[1]  = mk(1, 0, 0, 5'd1, 5'd0, 5'd1, 5'd0, 5'd0, 6'd0,     1);
      vecs[2]  = mk(1, 0, 0, 5'd1, 5'd0, 5'd0, 5'd1, 5'd0, 6'd0,     1);
      vecs[3]  = mk(1, 0, 0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0,     0);
      vecs[4]  = mk(0, 1, 0, 5'd0, 5'd1, 5'd1, 5'd0, 5'd0, 6'd0,     0);
      vecs[5]  = mk(0, 1, 0, 5'd0, 5'd1, 5'd1, 5'd0, 5'd0, 6'b000011, 1);
      vecs[6]  = mk(0, 0, 1, 5'd0, 5'd0, 5'd0, 5'd1, 5'd1, 6'b000011, 1);
      vecs[7]  = mk(0, 0, 1, 5'd0, 5'd0, 5'd0, 5'd1, 5'd0, 6'b000011, 0);
      vecs[8]  = mk(1, 0, 0, 5'd5, 5'd0, 5'd7, 5'd9, 5'd0, 6'd0,     0);
      vecs[9]  = mk(1, 0, 0, 5'd5, 5'd0, 5'd5, 5'd9, 5'd0, 6'b101011, 1);
      vecs[10] = mk(0, 1, 1, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'b000011, 0);
      vecs[11] = mk(0, 0, 1, 5'd0, 5'd4, 5'd4, 5'd0, 5'd0, 6'b000011, 0);

      // Reset state, including a hazardous input pattern gated by reset.
      applyCheck(idle, 1'b1, "reset_idle");
      loadUse = mk(1, 0, 0, 5'd3, 5'd0, 5'd3, 5'd0, 5'd0, 6'd0, 0);
      applyCheck(loadUse, 1'b1, "reset_gates_stall");

      for (int i = 0; i < 12; i++) begin
         applyCheck(vecs[i], 1'b0, $sformatf("vec%0d", i));
      end

      // Random nonzero register load-use matches on rs or rt.
      for (int i = 0; i < 4; i++) begin
         r  = 5'($urandom_range(1, 31));
         rv = mk(1, 0, 0, r, 5'd0, (i % 2 == 0) ? r : 5'd0, (i % 2 == 1) ? r : 5'd0,
                 5'd0, 6'($urandom_range(0, 63)), 1);
         applyCheck(rv, 1'b0, $sformatf("rand%0d", i));
      end

      // Clear, hold a load-use stall for 3 clocks, then reset mid-stall.
      applyCheck(idle, 1'b1, "clear");
      loadUse.expStall = 1'b1;
      for (int i = 0; i < 3; i++) applyCheck(loadUse, 1'b0, $sformatf("hold%0d", i));
      loadUse.expStall = 1'b0;
      applyCheck(loadUse, 1'b1, "reset_mid_stall");
      applyCheck(idle, 1'b0, "after_reset");

      // Five stall cycles: the 2-bit counter saturates at 3.
      loadUse.expStall = 1'b1;
      for (int i = 0; i < 5; i++) applyCheck(loadUse, 1'b0, $sformatf("sat%0d", i));
      applyCheck(idle, 1'b0, "sat_final");

      // Load-use plus both branch conditions: still one stall per cycle.
      applyCheck(idle, 1'b1, "clear2");
      both = mk(1, 1, 1, 5'd6, 5'd6, 5'd6, 5'd8, 5'd8, 6'b000011, 1);
      for (int i = 0; i < 3; i++) applyCheck(both, 1'b0, $sformatf("both%0d", i));
      applyCheck(idle, 1'b0, "both_final");

      // Load then branch: load-use, then the same reg in MEM stalls once more.
      applyCheck(idle, 1'b1, "clear3");
      applyCheck(mk(1, 0, 0, 5'd2, 5'd0, 5'd2, 5'd0, 5'd0, 6'b000011, 1), 1'b0, "ldbr_ex");
      applyCheck(mk(0, 0, 1, 5'd0, 5'd0, 5'd2, 5'd0, 5'd2, 6'b000011, 1), 1'b0, "ldbr_mem");
      applyCheck(mk(0, 0, 0, 5'd0, 5'd0, 5'd2, 5'd0, 5'd0, 6'b000011, 0), 1'b0, "ldbr_done");
      applyCheck(idle, 1'b0, "ldbr_final");

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
